// File: rtl/serv_ibus_pkg.sv
// rtl/serv_ibus_pkg.sv - shared types and state encoding for the ibus prefetcher
package serv_ibus_pkg;

    localparam int WORD_AW = 30;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEMAND   = 2'd1;
    localparam logic [1:0] ST_PREFETCH = 2'd2;

    typedef logic [WORD_AW-1:0] wadr_t;

endpackage

// File: rtl/serv_ibus_pfbuf.sv
// rtl/serv_ibus_pfbuf.sv - one-entry prefetch buffer with word-address hit compare
module serv_ibus_pfbuf
    import serv_ibus_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_inval,
    input  wadr_t       i_adr,
    input  logic [31:0] i_dat,
    input  wadr_t       i_cmp_adr,
    output logic        o_hit,
    output wadr_t       o_adr,
    output logic [31:0] o_dat
);

    logic buf_valid;

    // Invalidate wins so a flush can never be overtaken by a same-cycle fill.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            buf_valid <= 1'b0;
            o_adr     <= '0;
            o_dat     <= '0;
        end else if (i_inval) begin
            buf_valid <= 1'b0;
        end else if (i_load) begin
            buf_valid <= 1'b1;
            o_adr     <= i_adr;
            o_dat     <= i_dat;
        end
    end

    assign o_hit = buf_valid && (o_adr == i_cmp_adr);

endmodule

// File: rtl/serv_ibus_prefetch.sv
// rtl/serv_ibus_prefetch.sv - one-entry sequential instruction prefetcher on the Wishbone ibus
module serv_ibus_prefetch
    import serv_ibus_pkg::*;
#(
    parameter bit WITH_PREFETCH = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_cpu_adr,
    input  logic        i_cpu_cyc,
    output logic [31:0] o_cpu_rdt,
    output logic        o_cpu_ack,
    input  logic        i_flush,
    output logic [31:0] o_wb_adr,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack
);

    logic [1:0]  state;
    logic        match;
    logic        discard;
    logic        buf_hit;
    wadr_t       buf_adr;
    logic [31:0] buf_dat;

    wadr_t cpu_wadr;
    wadr_t wb_wadr;
    wadr_t wb_wadr_inc;
    wadr_t buf_adr_inc;
    logic  req;
    logic  hit;
    logic  pf_match;
    logic  match_nxt;
    logic  discard_nxt;
    logic  buf_load;
    logic  buf_inval;

    assign cpu_wadr    = i_cpu_adr[31:2];
    assign wb_wadr     = o_wb_adr[31:2];
    assign wb_wadr_inc = wb_wadr + 30'd1;
    assign buf_adr_inc = buf_adr + 30'd1;

    // The core still holds its request during the ack cycle; that is not a new fetch.
    assign req         = i_cpu_cyc && !o_cpu_ack;
    assign hit         = req && buf_hit && !i_flush;
    assign pf_match    = req && (cpu_wadr == wb_wadr);
    assign match_nxt   = match || pf_match;
    assign discard_nxt = discard || i_flush || (req && !pf_match);

    assign buf_load  = (state == ST_PREFETCH) && i_wb_ack && !discard_nxt && !match_nxt;
    assign buf_inval = i_flush || ((state == ST_IDLE) && req);

    serv_ibus_pfbuf u_pfbuf (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (buf_load),
        .i_inval   (buf_inval),
        .i_adr     (wb_wadr),
        .i_dat     (i_wb_rdt),
        .i_cmp_adr (cpu_wadr),
        .o_hit     (buf_hit),
        .o_adr     (buf_adr),
        .o_dat     (buf_dat)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            match     <= 1'b0;
            discard   <= 1'b0;
            o_cpu_ack <= 1'b0;
            o_cpu_rdt <= '0;
            o_wb_cyc  <= 1'b0;
            o_wb_adr  <= '0;
        end else begin
            o_cpu_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        o_cpu_ack <= 1'b1;
                        o_cpu_rdt <= buf_dat;
                        if (WITH_PREFETCH) begin
                            state    <= ST_PREFETCH;
                            o_wb_cyc <= 1'b1;
                            o_wb_adr <= {buf_adr_inc, 2'b00};
                        end
                    end else if (req) begin
                        state    <= ST_DEMAND;
                        o_wb_cyc <= 1'b1;
                        o_wb_adr <= {cpu_wadr, 2'b00};
                    end
                end
                ST_DEMAND: begin
                    if (i_wb_ack) begin
                        o_cpu_ack <= 1'b1;
                        o_cpu_rdt <= i_wb_rdt;
                        if (WITH_PREFETCH) begin
                            state    <= ST_PREFETCH;
                            o_wb_adr <= {wb_wadr_inc, 2'b00};
                        end else begin
                            state    <= ST_IDLE;
                            o_wb_cyc <= 1'b0;
                        end
                    end
                end
                ST_PREFETCH: begin
                    match   <= match_nxt;
                    discard <= discard_nxt;
                    // The bus cycle is never aborted; the decision is taken when it completes.
                    if (i_wb_ack) begin
                        match   <= 1'b0;
                        discard <= 1'b0;
                        if (discard_nxt) begin
                            if (req) begin
                                state    <= ST_DEMAND;
                                o_wb_adr <= {cpu_wadr, 2'b00};
                            end else begin
                                state    <= ST_IDLE;
                                o_wb_cyc <= 1'b0;
                            end
                        end else if (match_nxt) begin
                            o_cpu_ack <= 1'b1;
                            o_cpu_rdt <= i_wb_rdt;
                            o_wb_adr  <= {wb_wadr_inc, 2'b00};
                        end else begin
                            state    <= ST_IDLE;
                            o_wb_cyc <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    o_wb_cyc <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serv_ibus_prefetch.sv
// tb/tb_serv_ibus_prefetch.sv - self-checking bench for serv_ibus_prefetch
module tb_serv_ibus_prefetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] cpu_adr, cpu_rdt, wb_adr;
    logic [31:0] wb_rdt = '0;
    logic        cpu_cyc, cpu_ack, tb_flush, flush, wb_cyc;
    logic        wb_ack = 1'b0;
    logic        flush_on_ack;

    logic [31:0] c1_adr, c1_rdt, w1_adr;
    logic [31:0] w1_rdt = '0;
    logic        c1_cyc, c1_ack, w1_cyc;
    logic        w1_ack = 1'b0;

    assign flush = tb_flush | (flush_on_ack & wb_ack);

    serv_ibus_prefetch #(.WITH_PREFETCH(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_adr(cpu_adr), .i_cpu_cyc(cpu_cyc), .o_cpu_rdt(cpu_rdt), .o_cpu_ack(cpu_ack),
        .i_flush(flush),
        .o_wb_adr(wb_adr), .o_wb_cyc(wb_cyc), .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack)
    );

    serv_ibus_prefetch #(.WITH_PREFETCH(1'b0)) dut_nopf (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_adr(c1_adr), .i_cpu_cyc(c1_cyc), .o_cpu_rdt(c1_rdt), .o_cpu_ack(c1_ack),
        .i_flush(1'b0),
        .o_wb_adr(w1_adr), .o_wb_cyc(w1_cyc), .i_wb_rdt(w1_rdt), .i_wb_ack(w1_ack)
    );

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        if (a == 32'h4) return 32'h0010_0093;
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wishbone slave for the prefetching instance
    int          wb_lat = 2;
    int          wb_cnt = 0;
    int          last_ack_cyc = -100;
    logic [31:0] wb_log[$];
    always @(negedge clk) begin
        if (!rst_n) begin
            wb_ack = 1'b0;
            wb_cnt = 0;
        end else if (wb_ack) begin
            wb_ack = 1'b0;
            wb_cnt = 0;
        end else if (wb_cyc) begin
            if (wb_cnt >= wb_lat) begin
                wb_ack = 1'b1;
                wb_rdt = mem(wb_adr);
                wb_log.push_back(wb_adr);
                last_ack_cyc = cyc_n;
                wb_cnt = 0;
            end else begin
                wb_cnt++;
            end
        end else begin
            wb_cnt = 0;
        end
    end

    // Wishbone slave for the non-prefetching instance, plus a spurious-cycle monitor
    int w1_cnt = 0;
    int w1_reads = 0;
    int w1_spurious = 0;
    always @(negedge clk) begin
        if (!rst_n || w1_ack) begin
            w1_ack = 1'b0;
            w1_cnt = 0;
        end else if (w1_cyc) begin
            if (!c1_cyc) w1_spurious++;
            if (w1_cnt >= 1) begin
                w1_ack = 1'b1;
                w1_rdt = mem(w1_adr);
                w1_reads++;
                w1_cnt = 0;
            end else begin
                w1_cnt++;
            end
        end
    end

    // Scoreboard: expected words pushed by the fetch driver, popped on each core ack
    logic [31:0] exp_q[$];
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n && cpu_ack) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_ack: got rdt %h expected no ack", cpu_rdt);
            end else begin
                e = exp_q.pop_front();
                check("sb_rdt", cpu_rdt, e);
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input bit is_hit, input string tag,
                         output logic nc, output logic [31:0] na);
        int n;
        int logn;
        logn = wb_log.size();
        exp_q.push_back(mem(a));
        cpu_adr = a;
        cpu_cyc = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_ack && n < 50);
        if (!cpu_ack) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no ack in %0d cycles expected ack", tag, n);
        end else if (is_hit) begin
            check({tag, "_hit_lat"}, 32'(n), 32'd1);
            check({tag, "_hit_nobus"}, 32'(wb_log.size()), 32'(logn));
        end else begin
            check({tag, "_miss_lat"}, 32'(cyc_n - last_ack_cyc), 32'd1);
        end
        nc = wb_cyc;
        na = wb_adr;
        @(negedge clk);
        cpu_cyc = 1'b0;
    endtask

    task automatic fetch1(input logic [31:0] a);
        int n;
        c1_adr = a;
        c1_cyc = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!c1_ack && n < 50);
        check("nopf_rdt", c1_rdt, c1_ack ? mem(a) : 32'hDEAD_BEEF ^ mem(a));
        @(negedge clk);
        c1_cyc = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] adr;
        int          gap;
        bit          hit;
    } vec_t;

    vec_t        tbl[8];
    logic        nc;
    logic [31:0] na;
    int          logn;
    int          n;

    initial begin
        tbl[0] = '{32'h0000_0000, 0, 1'b0};  // cold miss
        tbl[1] = '{32'h0000_0004, 8, 1'b1};  // buffered prefetch hit
        tbl[2] = '{32'h0000_0100, 0, 1'b0};  // jump while 0x8 in flight
        tbl[3] = '{32'h0000_0104, 0, 1'b0};  // matches in-flight prefetch
        tbl[4] = '{32'h0000_0108, 8, 1'b1};
        tbl[5] = '{32'h0000_010C, 1, 1'b0};
        tbl[6] = '{32'hFFFF_FFFC, 0, 1'b0};  // jump to top of memory
        tbl[7] = '{32'h0000_0000, 8, 1'b1};  // wrapped prefetch hit

        rst_n = 1'b0;
        cpu_adr = '0; cpu_cyc = 1'b0; tb_flush = 1'b0; flush_on_ack = 1'b0;
        c1_adr = '0; c1_cyc = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdt", cpu_rdt, 32'h0);
        check("rst_wb_adr", wb_adr, 32'h0);
        check("rst_ack_cyc", {30'b0, cpu_ack, wb_cyc}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            repeat (tbl[i].gap) @(negedge clk);
            fetch(tbl[i].adr, tbl[i].hit, $sformatf("v%0d", i), nc, na);
            check($sformatf("v%0d_next_cyc", i), {31'b0, nc}, 32'h1);
            check($sformatf("v%0d_next_adr", i), na, tbl[i].adr + 32'd4);
        end

        // Flush coinciding with the prefetch ack of 0x4: data must not be buffered
        logn = wb_log.size();
        flush_on_ack = 1'b1;
        n = 0;
        while (wb_log.size() == logn && n < 20) begin
            @(negedge clk);
            n++;
        end
        flush_on_ack = 1'b0;
        check("flush_ack_adr", (wb_log.size() > logn) ? wb_log[logn] : 32'hFFFF_FFFF, 32'h4);
        repeat (3) @(negedge clk);
        check("flush_ack_idle", {31'b0, wb_cyc}, 32'h0);
        fetch(32'h4, 1'b0, "flush_ack_refetch", nc, na);

        // Flush while idle with 0x8 buffered
        repeat (8) @(negedge clk);
        tb_flush = 1'b1;
        @(negedge clk);
        tb_flush = 1'b0;
        fetch(32'h8, 1'b0, "idle_flush_refetch", nc, na);

        // Asynchronous reset in the middle of a demand fetch
        repeat (8) @(negedge clk);
        wb_lat = 6;
        cpu_adr = 32'h200;
        cpu_cyc = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_rst_wb_cyc", {31'b0, wb_cyc}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_wb_cyc", {31'b0, wb_cyc}, 32'h0);
        check("async_rst_ack", {31'b0, cpu_ack}, 32'h0);
        check("async_rst_rdt", cpu_rdt, 32'h0);
        check("async_rst_wb_adr", wb_adr, 32'h0);
        cpu_cyc = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wb_lat = 2;
        @(negedge clk);
        fetch(32'hC, 1'b0, "post_rst", nc, na);
        repeat (8) @(negedge clk);

        // Non-prefetching instance: every fetch is a bus read, nothing speculative
        fetch1(32'h0);
        fetch1(32'h4);
        fetch1(32'h4);
        fetch1(32'h8);
        repeat (5) @(negedge clk);
        check("nopf_reads", 32'(w1_reads), 32'd4);
        check("nopf_spurious", 32'(w1_spurious), 32'd0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule
